// File: rtl/ltc2175_frame_align.sv
// LTC2175 frame-lane word alignment controller.
// Issues ISERDES2 bitslip pulses until the FR word matches, then tracks lock.
module ltc2175_frame_align #(
    parameter int unsigned FRAME_W       = 8,
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned MATCH_CNT     = 16,
    parameter int unsigned LOSS_CNT      = 4,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_word,
    output logic               bitslip,
    output logic               busy,
    output logic               locked,
    output logic               fail,
    output logic [3:0]         slip_count,
    output logic [7:0]         relock_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam logic [FRAME_W-1:0] PAT        = FRAME_PATTERN[FRAME_W-1:0];
    localparam logic [3:0]         SLIP_MAX   = 4'(FRAME_W - 1);
    localparam logic [3:0]         WAIT_LAST  = 4'(SETTLE_CYC - 1);
    localparam logic [7:0]         MATCH_LAST = 8'(MATCH_CNT - 1);
    localparam logic [7:0]         LOSS_LAST  = 8'(LOSS_CNT - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] wait_cnt;
    logic [3:0] wait_n;
    logic [7:0] match_cnt;
    logic [7:0] match_n;
    logic [7:0] miss_cnt;
    logic [7:0] miss_n;
    logic [3:0] slip_n;
    logic [7:0] relock_n;
    logic       auto_pend;
    logic       restart;
    logic       hit;

    assign hit = (frame_word == PAT);

    // Next-state and counter updates; start overrides every other transition.
    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        match_n  = match_cnt;
        miss_n   = miss_cnt;
        slip_n   = slip_count;
        relock_n = relock_count;
        restart  = 1'b0;
        if (start) begin
            restart = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (AUTO_START && auto_pend) begin
                        restart = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_n = S_CHECK;
                    end else begin
                        wait_n = wait_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        match_n = match_cnt + 8'd1;
                        if (match_cnt == MATCH_LAST) begin
                            state_n = S_LOCKED;
                        end
                    end else if (slip_count == SLIP_MAX) begin
                        state_n = S_FAIL;
                    end else begin
                        match_n = 8'd0;
                        state_n = S_SLIP;
                    end
                end
                S_SLIP: begin
                    slip_n  = slip_count + 4'd1;
                    wait_n  = 4'd0;
                    state_n = S_SETTLE;
                end
                S_LOCKED: begin
                    if (hit) begin
                        miss_n = 8'd0;
                    end else if (miss_cnt == LOSS_LAST) begin
                        restart = 1'b1;
                        if (relock_count != 8'hFF) begin
                            relock_n = relock_count + 8'd1;
                        end
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
        if (restart) begin
            state_n = S_SETTLE;
            wait_n  = 4'd0;
            match_n = 8'd0;
            miss_n  = 8'd0;
            slip_n  = 4'd0;
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            match_cnt    <= 8'd0;
            miss_cnt     <= 8'd0;
            slip_count   <= 4'd0;
            relock_count <= 8'd0;
            auto_pend    <= 1'b1;
            bitslip      <= 1'b0;
            busy         <= 1'b0;
            locked       <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= wait_n;
            match_cnt    <= match_n;
            miss_cnt     <= miss_n;
            slip_count   <= slip_n;
            relock_count <= relock_n;
            auto_pend    <= 1'b0;
            bitslip      <= (state_n == S_SLIP);
            busy         <= (state_n == S_SETTLE) || (state_n == S_CHECK) ||
                            (state_n == S_SLIP);
            locked       <= (state_n == S_LOCKED);
            fail         <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_ltc2175_frame_align.sv
// Bench for ltc2175_frame_align: ISERDES rotation environment,
// cycle reference model, table-driven alignment cases and random traffic.
module tb_ltc2175_frame_align;

    localparam logic [7:0] PAT = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] frame_word;
    logic       bitslip;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [3:0] slip_count;
    logic [7:0] relock_count;

    int n_chk  = 0;
    int n_fail = 0;

    // environment: 0 rotating ISERDES, 1 fixed word, 2 alternating
    int         mode;
    int         rot;
    logic [7:0] fix_word;
    bit         alt;
    int         noise;

    // reference model
    localparam int PH_IDLE   = 0;
    localparam int PH_SETTLE = 1;
    localparam int PH_CHECK  = 2;
    localparam int PH_SLIP   = 3;
    localparam int PH_LOCKED = 4;
    localparam int PH_FAIL   = 5;
    int ph;
    int m_left;
    int m_match;
    int m_miss;
    int m_slips;
    int m_relock;
    bit m_first;

    // pulse tracking
    int pulses;
    int run_len;
    int max_w;
    int gap;
    int min_gap;
    bit prev_bs;
    bit ever_locked;

    typedef struct {
        int rot;
        int mode;
        int exp_pulses;
        int exp_lat;
        bit exp_locked;
        bit exp_fail;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    ltc2175_frame_align dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_word   (frame_word),
        .bitslip      (bitslip),
        .busy         (busy),
        .locked       (locked),
        .fail         (fail),
        .slip_count   (slip_count),
        .relock_count (relock_count)
    );

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [15:0] d;
        int s;
        s = ((k % 8) + 8) % 8;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    function automatic logic [7:0] gen_word();
        case (mode)
            0:       return rotl(PAT, rot);
            1:       return fix_word;
            default: return alt ? PAT : ~PAT;
        endcase
    endfunction

    task automatic set_word();
        frame_word = gen_word();
    endtask

    task automatic m_begin();
        ph      = PH_SETTLE;
        m_left  = 4;
        m_match = 0;
        m_miss  = 0;
        m_slips = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input logic [7:0] w);
        bit hit;
        bit first;
        hit     = (w == PAT);
        first   = m_first;
        m_first = r;
        if (r) begin
            ph = PH_IDLE;
            m_left = 0; m_match = 0; m_miss = 0;
            m_slips = 0; m_relock = 0;
            return;
        end
        if (s || (ph == PH_IDLE && first)) begin
            m_begin();
            return;
        end
        case (ph)
            PH_SETTLE: begin
                m_left--;
                if (m_left == 0) ph = PH_CHECK;
            end
            PH_CHECK: begin
                if (hit) begin
                    m_match++;
                    if (m_match == 16) ph = PH_LOCKED;
                end else if (m_slips == 7) begin
                    ph = PH_FAIL;
                end else begin
                    m_match = 0;
                    ph = PH_SLIP;
                end
            end
            PH_SLIP: begin
                m_slips++;
                m_left = 4;
                ph = PH_SETTLE;
            end
            PH_LOCKED: begin
                if (hit) begin
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == 4) begin
                        if (m_relock < 255) m_relock++;
                        m_begin();
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic [17:0] act;
        logic [17:0] exp;
        act = {bitslip, busy, locked, fail, slip_count, relock_count};
        exp = {ph == PH_SLIP,
               ph == PH_SETTLE || ph == PH_CHECK || ph == PH_SLIP,
               ph == PH_LOCKED, ph == PH_FAIL,
               4'(m_slips), 8'(m_relock)};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t bs/busy/lk/fl/sc/rc act=%b/%0d exp=%b/%0d",
                     $time, act[17:14], act[13:0], exp[17:14], exp[13:0]);
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic track_clear();
        pulses = 0; run_len = 0; max_w = 0; gap = 0;
        min_gap = 999; prev_bs = 0; ever_locked = 0;
    endtask

    task automatic track();
        if (bitslip && !prev_bs) begin
            if (pulses > 0 && gap < min_gap) min_gap = gap;
            pulses++;
        end
        if (bitslip) begin
            run_len++;
            if (run_len > max_w) max_w = run_len;
            gap = 0;
        end else begin
            run_len = 0;
            gap++;
        end
        if (locked) ever_locked = 1;
        prev_bs = bitslip;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, start, frame_word);
        @(negedge clk);
        check_model();
        if (bitslip) rot = rot - 1;
        alt = ~alt;
        frame_word = gen_word();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int held;
        int r0;
        rst = 1'b1; start = 1'b0; mode = 1; fix_word = 8'h00;
        rot = 0; alt = 1'b0; noise = 0; frame_word = 8'h00;
        ph = PH_IDLE; m_first = 1'b0; m_left = 0; m_match = 0;
        m_miss = 0; m_slips = 0; m_relock = 0;
        track_clear();

        tbl[0] = '{3, 0, 3, 39, 1'b1, 1'b0};
        tbl[1] = '{0, 0, 0, 21, 1'b1, 1'b0};
        tbl[2] = '{5, 0, 5, 51, 1'b1, 1'b0};
        tbl[3] = '{7, 0, 7, 63, 1'b1, 1'b0};
        tbl[4] = '{0, 1, 7, 48, 1'b0, 1'b1};

        // reset values
        repeat (3) tick();
        expect_eq("reset_outputs",
                  int'({bitslip, busy, locked, fail, slip_count, relock_count}), 0);

        // aligned word, auto start after reset release
        mode = 0; rot = 0; set_word();
        rst = 1'b0;
        track_clear();
        lat = 0;
        while (!locked && lat < 60) begin
            tick(); track(); lat++;
        end
        expect_eq("auto_lock_latency", lat, 21);
        expect_eq("auto_lock_pulses", pulses, 0);
        expect_eq("auto_locked", int'(locked), 1);

        // table of alignment attempts
        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode; rot = tbl[i].rot; fix_word = 8'h00;
            set_word();
            track_clear();
            pulse_start(); track();
            lat = 1;
            while (!(locked || fail) && lat < 200) begin
                tick(); track(); lat++;
            end
            expect_eq($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            expect_eq($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
            expect_eq($sformatf("tbl%0d_width", i), int'(max_w <= 1), 1);
            expect_eq($sformatf("tbl%0d_gap", i), int'(pulses < 2 || min_gap >= 5), 1);
            expect_eq($sformatf("tbl%0d_slip_count", i), int'(slip_count),
                      tbl[i].exp_pulses);
            expect_eq($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
            expect_eq($sformatf("tbl%0d_fail", i), int'(fail), int'(tbl[i].exp_fail));
        end

        // fail is sticky, then cleared by start
        held = 0;
        repeat (100) begin
            tick();
            if (fail && !busy && !locked) held++;
        end
        expect_eq("fail_sticky_cycles", held, 100);
        pulse_start();
        expect_eq("fail_cleared", int'(fail), 0);
        expect_eq("busy_after_restart", int'(busy), 1);

        // loss-of-lock handling
        mode = 0; rot = 0; set_word();
        pulse_start();
        lat = 1;
        while (!locked && lat < 100) begin
            tick(); lat++;
        end
        expect_eq("pre_loss_locked", int'(locked), 1);
        r0 = relock_count;
        mode = 1;
        for (int k = 0; k < 4; k++) begin
            fix_word = (k == 3) ? PAT : 8'h0F;
            set_word(); tick();
            expect_eq($sformatf("hold_locked_%0d", k), int'(locked), 1);
        end
        fix_word = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            set_word(); tick();
            expect_eq($sformatf("loss_locked_%0d", k), int'(locked), (k == 3) ? 0 : 1);
        end
        expect_eq("relock_count", int'(relock_count), r0 + 1);
        expect_eq("relock_busy", int'(busy), 1);
        mode = 0; rot = 0; set_word();
        lat = 0;
        while (!locked && lat < 100) begin
            tick(); lat++;
        end
        expect_eq("relock_latency", lat, 20);
        expect_eq("relock_slips", int'(slip_count), 0);

        // start during SETTLE right after a bitslip
        mode = 0; rot = 2; set_word();
        pulse_start();
        lat = 1;
        while (!bitslip && lat < 50) begin
            tick(); lat++;
        end
        expect_eq("first_slip_seen", int'(bitslip), 1);
        tick();
        expect_eq("slip_count_after_slip", int'(slip_count), 1);
        pulse_start();
        expect_eq("slip_count_cleared", int'(slip_count), 0);
        lat = 0;
        while (!bitslip && lat < 50) begin
            tick(); lat++;
        end
        expect_eq("restart_settle_len", lat, 5);

        // reset while in CHECK
        mode = 0; rot = 0; set_word();
        pulse_start();
        repeat (6) tick();
        expect_eq("busy_in_check", int'(busy), 1);
        rst = 1'b1;
        tick();
        expect_eq("rst_in_check",
                  int'({bitslip, busy, locked, fail, slip_count, relock_count}), 0);
        rst = 1'b0;

        // alternating match/mismatch never locks
        mode = 2; set_word();
        track_clear();
        pulse_start(); track();
        lat = 1;
        while (!fail && lat < 300) begin
            tick(); track(); lat++;
        end
        expect_eq("alt_pulses", pulses, 7);
        expect_eq("alt_fail", int'(fail), 1);
        expect_eq("alt_never_locked", int'(ever_locked), 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 49) == 0) begin
                mode  = $urandom_range(0, 2);
                rot   = $urandom_range(0, 7);
                noise = $urandom_range(0, 8);
            end
            if (mode == 1) begin
                fix_word = ($urandom_range(0, 15) < noise) ? 8'($urandom) : PAT;
            end
            set_word();
            tick();
        end
        rst = 1'b0; start = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
